frame_packager: RTL and testbench

Parametrised successor to the ADC byte packager. Snapshots `ADC_COUNT` channels of `ADC_DATA_WIDTH`-bit samples and serialises them as one framed byte stream: sync byte, sequence number, MSB-first payload and an optional checksum. Output uses a strict valid/ready handshake toward the transmit interface (UART/USB FIFO writer). It double-buffers samples, so new ADC data may arrive while a frame is in flight. Dropped sync requests are flagged.

---
 rtl/frame_packager_if.sv | 29 ++
 rtl/frame_packager.sv | 234 +++++++++++++++++++++++
 tb/tb_frame_packager.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_packager_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_packager_if
//  Description : Byte-wide valid/ready transmit bus between the frame
//                packager and its sink (UART / USB FIFO writer).
//                  tx_valid : source -> sink, tx_data is valid
//                  tx_data  : source -> sink, byte on offer
//                  tx_ready : sink -> source, sink accepts a byte this cycle
//                A byte moves on every cycle where tx_valid && tx_ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_packager_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/frame_packager.sv
`default_nettype none
// ============================================================================
//  Module      : frame_packager
//  Description : Snapshots ADC_COUNT samples of ADC_DATA_WIDTH bits and
//                serialises them as one framed byte stream:
//                  SYNC_BYTE, sequence number, payload (channel 0 first,
//                  MSB byte first within a channel) [, checksum].
//                Samples are double buffered (input buffer + frame buffer)
//                so new ADC data may arrive while a frame is in flight.
//                A sync request that cannot be accepted raises a one-cycle
//                overrun pulse.
//
//  Build option: define FRAME_PACKAGER_CSUM_EN to append a checksum byte
//                (two's complement of the 8-bit sum of SEQ and payload).
//
//  Parameters  : ADC_DATA_WIDTH  sample width, multiple of 8, 8..32
//                ADC_COUNT       number of channels, 1..16
//                SYNC_BYTE       first byte of every frame
//
//  Ports       : mclkin        clock, rising edge
//                rst           synchronous active-high reset
//                data_adc      packed samples, channel k at [k*W +: W]
//                write_enable  load data_adc into the input buffer
//                sync_pulse    frame start request
//                tx            transmit bus (master side)
//                busy          frame in progress
//                overrun       one-cycle pulse per dropped sync request
//                seq_num       sequence number of the next frame
//
//  Revision    : 1.0  initial release
// ============================================================================
module frame_packager #(
    parameter int         ADC_DATA_WIDTH = 16,
    parameter int         ADC_COUNT      = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hFF
) (
    input  logic                                mclkin,
    input  logic                                rst,
    input  logic [ADC_COUNT*ADC_DATA_WIDTH-1:0] data_adc,
    input  logic                                write_enable,
    input  logic                                sync_pulse,
    frame_packager_if.master                    tx,
    output logic                                busy,
    output logic                                overrun,
    output logic [7:0]                          seq_num
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_TOTAL_BITS = ADC_COUNT * ADC_DATA_WIDTH;
    localparam int c_BYTES      = ADC_DATA_WIDTH / 8;   // bytes per channel
    // Index widths are kept at least one bit wide so single-byte samples and
    // single-channel builds still elaborate cleanly.
    localparam int c_BI_W       = (c_BYTES   > 1) ? $clog2(c_BYTES)   : 1;
    localparam int c_CI_W       = (ADC_COUNT > 1) ? $clog2(ADC_COUNT) : 1;

    localparam logic [c_BI_W-1:0] c_LAST_BYTE = c_BI_W'(c_BYTES - 1);
    localparam logic [c_CI_W-1:0] c_LAST_CH   = c_CI_W'(ADC_COUNT - 1);
    localparam logic [c_BI_W-1:0] c_BI_ONE    = c_BI_W'(1);
    localparam logic [c_CI_W-1:0] c_CI_ONE    = c_CI_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_SEQ  = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
`ifdef FRAME_PACKAGER_CSUM_EN
    localparam logic [2:0] c_ST_CSUM = 3'd4;
`endif

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [2:0]              r_state;
    logic [c_TOTAL_BITS-1:0] r_in_buf;
    logic [c_TOTAL_BITS-1:0] r_frame_buf;
    logic [c_BI_W-1:0]       r_byte_idx;
    logic [c_CI_W-1:0]       r_ch_idx;
    logic [7:0]              r_seq;
    logic                    r_overrun;
`ifdef FRAME_PACKAGER_CSUM_EN
    logic [7:0]              r_csum;
`endif

    logic                    w_xfer;
    logic                    w_last_payload;
    logic [7:0]              w_payload_byte;
    logic [7:0]              w_tx_data;

    // A byte leaves the block whenever the sink accepts an offered byte.
    // tx_valid is purely a function of state, so it can only drop after the
    // state machine has seen the transfer.
    assign w_xfer         = (r_state != c_ST_IDLE) && tx.tx_ready;
    assign w_last_payload = (r_byte_idx == c_LAST_BYTE) && (r_ch_idx == c_LAST_CH);

    // ------------------------------------------------------------------------
    // Payload byte select: channel r_ch_idx, byte r_byte_idx counted from the
    // MSB end of the sample.
    // ------------------------------------------------------------------------
    always_comb begin
        w_payload_byte = 8'h00;
        for (int k = 0; k < ADC_COUNT; k++) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if ((r_ch_idx == c_CI_W'(k)) && (r_byte_idx == c_BI_W'(b))) begin
                    w_payload_byte = r_frame_buf[k*ADC_DATA_WIDTH + (c_BYTES-1-b)*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte on offer. Driven from registered state only, so it is stable for as
    // long as the sink holds tx_ready low.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            c_ST_HDR:  w_tx_data = SYNC_BYTE;
            c_ST_SEQ:  w_tx_data = r_seq;
            c_ST_DATA: w_tx_data = w_payload_byte;
`ifdef FRAME_PACKAGER_CSUM_EN
            // Negated running sum makes SEQ + payload + csum == 0 mod 256.
            c_ST_CSUM: w_tx_data = 8'(8'd0 - r_csum);
`endif
            default:   w_tx_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------------
    // Buffers, frame sequencer and sequence counter
    // ------------------------------------------------------------------------
    always_ff @(posedge mclkin) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_in_buf    <= '0;
            r_frame_buf <= '0;
            r_byte_idx  <= '0;
            r_ch_idx    <= '0;
            r_seq       <= 8'h00;
            r_overrun   <= 1'b0;
`ifdef FRAME_PACKAGER_CSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            // Any request outside IDLE is lost, including the cycle that
            // carries the final byte of a frame.
            r_overrun <= sync_pulse && (r_state != c_ST_IDLE);

            // The input buffer follows write_enable regardless of state.
            if (write_enable) begin
                r_in_buf <= data_adc;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (sync_pulse) begin
                        // Same-cycle write bypasses the input buffer so the
                        // frame carries the sample presented with the sync.
                        r_frame_buf <= write_enable ? data_adc : r_in_buf;
                        r_byte_idx  <= '0;
                        r_ch_idx    <= '0;
`ifdef FRAME_PACKAGER_CSUM_EN
                        r_csum      <= 8'h00;
`endif
                        r_state     <= c_ST_HDR;
                    end
                end

                c_ST_HDR: begin
                    if (w_xfer) begin
                        r_state <= c_ST_SEQ;
                    end
                end

                c_ST_SEQ: begin
                    if (w_xfer) begin
`ifdef FRAME_PACKAGER_CSUM_EN
                        r_csum  <= r_csum + r_seq;
`endif
                        r_state <= c_ST_DATA;
                    end
                end

                c_ST_DATA: begin
                    if (w_xfer) begin
`ifdef FRAME_PACKAGER_CSUM_EN
                        r_csum <= r_csum + w_payload_byte;
`endif
                        if (w_last_payload) begin
`ifdef FRAME_PACKAGER_CSUM_EN
                            r_state <= c_ST_CSUM;
`else
                            r_state <= c_ST_IDLE;
                            r_seq   <= r_seq + 8'd1;
`endif
                        end else if (r_byte_idx == c_LAST_BYTE) begin
                            r_byte_idx <= '0;
                            r_ch_idx   <= r_ch_idx + c_CI_ONE;
                        end else begin
                            r_byte_idx <= r_byte_idx + c_BI_ONE;
                        end
                    end
                end

`ifdef FRAME_PACKAGER_CSUM_EN
                c_ST_CSUM: begin
                    if (w_xfer) begin
                        r_state <= c_ST_IDLE;
                        r_seq   <= r_seq + 8'd1;
                    end
                end
`endif

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx.tx_valid = (r_state != c_ST_IDLE);
    assign tx.tx_data  = w_tx_data;
    assign busy        = (r_state != c_ST_IDLE);
    assign overrun     = r_overrun;
    assign seq_num     = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_frame_packager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_packager
//  Description : Self-checking bench for frame_packager. Expected bytes are
//                produced by a small frame model into a queue when stimulus
//                is driven; a monitor collects transferred bytes and each
//                test task compares them in order. A second instance covers
//                ADC_DATA_WIDTH=24, ADC_COUNT=1. Honours
//                FRAME_PACKAGER_CSUM_EN for frame length and checksum.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_packager;

    localparam int W   = 16;
    localparam int N   = 6;
    localparam int TOT = W * N;
`ifdef FRAME_PACKAGER_CSUM_EN
    localparam int L   = 3 + N * W / 8;
`else
    localparam int L   = 2 + N * W / 8;
`endif
    localparam int BUDGET = 3000;

    logic            mclkin = 1'b0;
    logic            rst;
    logic [TOT-1:0]  data_adc;
    logic            write_enable, sync_pulse;
    logic            busy, overrun;
    logic [7:0]      seq_num;

    logic [23:0]     data1;
    logic            we1, sync1, busy1, ovr1;
    logic [7:0]      seq1;

    frame_packager_if tx0 ();
    frame_packager_if tx1 ();

    always #5 mclkin = ~mclkin;

    frame_packager #(.ADC_DATA_WIDTH(W), .ADC_COUNT(N), .SYNC_BYTE(8'hFF)) dut0 (
        .mclkin(mclkin), .rst(rst), .data_adc(data_adc), .write_enable(write_enable),
        .sync_pulse(sync_pulse), .tx(tx0), .busy(busy), .overrun(overrun), .seq_num(seq_num)
    );

    frame_packager #(.ADC_DATA_WIDTH(24), .ADC_COUNT(1), .SYNC_BYTE(8'hFF)) dut1 (
        .mclkin(mclkin), .rst(rst), .data_adc(data1), .write_enable(we1),
        .sync_pulse(sync1), .tx(tx1), .busy(busy1), .overrun(ovr1), .seq_num(seq1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_t [$];
    logic [7:0] got1_q[$];

    int         ovr_cnt  = 0;
    int         unstable = 0;
    logic       hold_v   = 1'b0;
    logic [7:0] hold_d   = 8'h00;

    logic [7:0]     m_seq;
    logic [TOT-1:0] m_inbuf;
    int             s_cyc;

    always @(posedge mclkin) cyc <= cyc + 1;

    // Monitor: records transfers with their cycle stamp, counts overrun
    // pulses and any change of an offered byte while the sink is stalled.
    always @(negedge mclkin) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && (!tx0.tx_valid || tx0.tx_data !== hold_d)) unstable <= unstable + 1;
            hold_v <= tx0.tx_valid && !tx0.tx_ready;
            hold_d <= tx0.tx_data;
            if (tx0.tx_valid && tx0.tx_ready) begin
                got_q.push_back(tx0.tx_data);
                got_t.push_back(cyc);
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (tx1.tx_valid && tx1.tx_ready) got1_q.push_back(tx1.tx_data);
        end
    end

    // ---------------- model and stimulus helpers (no checking) --------------
    task automatic push_frame(input logic [7:0] s, input logic [TOT-1:0] d);
        logic [7:0] sum;
        logic [7:0] b;
        sum = s;
        exp_q.push_back(8'hFF);
        exp_q.push_back(s);
        for (int k = 0; k < N; k++) begin
            for (int j = W / 8 - 1; j >= 0; j--) begin
                b = d[k*W + j*8 +: 8];
                exp_q.push_back(b);
                sum = sum + b;
            end
        end
`ifdef FRAME_PACKAGER_CSUM_EN
        exp_q.push_back(8'(8'd0 - sum));
`endif
    endtask

    task automatic load_data(input logic [TOT-1:0] d);
        @(posedge mclkin); #1;
        data_adc = d; write_enable = 1'b1;
        @(posedge mclkin); #1;
        write_enable = 1'b0;
        m_inbuf = d;
    endtask

    task automatic start_frame();
        @(posedge mclkin); #1;
        sync_pulse = 1'b1; s_cyc = cyc;
        push_frame(m_seq, m_inbuf);
        m_seq = m_seq + 8'd1;
        @(posedge mclkin); #1;
        sync_pulse = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input bit pat, output bit to);
        int k;
        k = 0; to = 1'b0;
        while (got_q.size() < n) begin
            if (k > BUDGET) begin to = 1'b1; break; end
            @(posedge mclkin); #1;
            tx0.tx_ready = pat ? ((k % 3) == 0) : 1'b1;
            k++;
        end
        tx0.tx_ready = 1'b1;
    endtask

    function automatic logic [TOT-1:0] basic_data();
        logic [TOT-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = {8'(2*k + 1), 8'(2*k + 2)};
        return d;
    endfunction

    // ------------------------------- tests ----------------------------------
    task automatic test_reset();
        @(negedge mclkin);
        total++; if (tx0.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", tx0.tx_valid); end
        total++; if (tx0.tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", tx0.tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (seq_num !== 8'h00) begin bad++; $display("FAIL reset_seq got=%h exp=00", seq_num); end
        total++; if (tx1.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b exp=0", tx1.tx_valid); end
        @(posedge mclkin); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        logic [7:0] e, g;
        load_data(basic_data());
        start_frame();
        @(negedge mclkin);
        total++; if (tx0.tx_valid !== 1'b1 || tx0.tx_data !== 8'hFF || busy !== 1'b1) begin
            bad++; $display("FAIL basic_first valid=%b data=%h busy=%b exp 1/FF/1", tx0.tx_valid, tx0.tx_data, busy);
        end
        wait_bytes(L, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=%0d bytes exp=%0d", got_q.size(), L); end
        if (!to) begin
            total++; if (got_t[0] !== s_cyc + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", got_t[0], s_cyc + 1); end
            total++; if (got_t[L-1] - got_t[0] !== L - 1) begin bad++; $display("FAIL basic_bubbles got=%0d exp=%0d", got_t[L-1] - got_t[0], L - 1); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (got_t.size() > 0) void'(got_t.pop_front());
            total++; if (g !== e) begin bad++; $display("FAIL basic_byte got=%h exp=%h", g, e); end
        end
        @(negedge mclkin);
        total++; if (tx0.tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_end valid=%b busy=%b exp 0/0", tx0.tx_valid, busy); end
        total++; if (seq_num !== m_seq) begin bad++; $display("FAIL basic_seq got=%h exp=%h", seq_num, m_seq); end
    endtask

    task automatic test_backpressure();
        bit to;
        int base;
        logic [7:0] e, g;
        base = unstable;
        start_frame();
        wait_bytes(L, 1'b1, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=%0d bytes exp=%0d", got_q.size(), L); end
        repeat (5) @(posedge mclkin);
        @(negedge mclkin);
        total++; if (got_q.size() !== L) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), L); end
        total++; if (unstable - base !== 0) begin bad++; $display("FAIL bp_stable got=%0d changes exp=0", unstable - base); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (got_t.size() > 0) void'(got_t.pop_front());
            total++; if (g !== e) begin bad++; $display("FAIL bp_byte got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_t.delete();
        total++; if (seq_num !== m_seq) begin bad++; $display("FAIL bp_seq got=%h exp=%h", seq_num, m_seq); end
    endtask

    task automatic test_overrun();
        bit to;
        int base;
        logic [7:0] e, g;
        logic [TOT-1:0] aa, ff;
        aa = {N{16'hAAAA}};
        ff = {N{16'h5A5A}};
        base = ovr_cnt;
        start_frame();
        repeat (3) begin @(posedge mclkin); #1; end
        data_adc = aa; write_enable = 1'b1; sync_pulse = 1'b1;
        @(posedge mclkin); #1;
        write_enable = 1'b0; sync_pulse = 1'b0;
        m_inbuf = aa;
        wait_bytes(L, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL ovr_timeout got=%0d bytes exp=%0d", got_q.size(), L); end
        repeat (5) @(posedge mclkin);
        @(negedge mclkin);
        total++; if (tx0.tx_valid !== 1'b0 || got_q.size() !== L) begin
            bad++; $display("FAIL ovr_nostart valid=%b bytes=%0d exp 0/%0d", tx0.tx_valid, got_q.size(), L);
        end
        total++; if (ovr_cnt - base !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - base); end
        // Next accepted sync carries the buffered AA samples, then a
        // same-cycle write + sync carries the bypassed samples.
        @(posedge mclkin); #1;
        start_frame();
        wait_bytes(2 * L, 1'b0, to);
        @(posedge mclkin); #1;
        data_adc = ff; write_enable = 1'b1; sync_pulse = 1'b1;
        push_frame(m_seq, ff); m_seq = m_seq + 8'd1; m_inbuf = ff;
        @(posedge mclkin); #1;
        write_enable = 1'b0; sync_pulse = 1'b0;
        wait_bytes(3 * L, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL ovr_timeout2 got=%0d bytes exp=%0d", got_q.size(), 3 * L); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (got_t.size() > 0) void'(got_t.pop_front());
            total++; if (g !== e) begin bad++; $display("FAIL ovr_byte got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_t.delete();
    endtask

    task automatic test_back_to_back();
        bit to;
        int base;
        logic [7:0] e, g;
        base = ovr_cnt;
        @(posedge mclkin); #1;
        sync_pulse = 1'b1; s_cyc = cyc;
        push_frame(m_seq, m_inbuf); m_seq = m_seq + 8'd1;
        push_frame(m_seq, m_inbuf); m_seq = m_seq + 8'd1;
        repeat (L + 2) begin @(posedge mclkin); #1; end
        sync_pulse = 1'b0;
        wait_bytes(2 * L, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL b2b_timeout got=%0d bytes exp=%0d", got_q.size(), 2 * L); end
        if (!to) begin
            total++; if (got_t[0] !== s_cyc + 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", got_t[0], s_cyc + 1); end
            total++; if (got_t[L] - got_t[L-1] !== 2) begin bad++; $display("FAIL b2b_gap got=%0d exp=2", got_t[L] - got_t[L-1]); end
        end
        @(negedge mclkin);
        total++; if (ovr_cnt - base !== L) begin bad++; $display("FAIL b2b_overruns got=%0d exp=%0d", ovr_cnt - base, L); end
        total++; if (seq_num !== m_seq) begin bad++; $display("FAIL b2b_seq got=%h exp=%h", seq_num, m_seq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (got_t.size() > 0) void'(got_t.pop_front());
            total++; if (g !== e) begin bad++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_t.delete();
    endtask

    task automatic test_wrap();
        bit to;
        int nf;
        logic [7:0] e, g;
        nf = 256 - int'(m_seq);
        for (int f = 0; f <= nf; f++) begin
            if (f == nf) begin
                @(negedge mclkin);
                total++; if (seq_num !== 8'h00) begin bad++; $display("FAIL wrap_seq got=%h exp=00", seq_num); end
            end
            start_frame();
            wait_bytes(L, 1'b0, to);
            total++; if (to) begin bad++; $display("FAIL wrap_timeout frame=%0d got=%0d", f, got_q.size()); end
            if (f == nf && got_q.size() > 1) begin
                total++; if (got_q[1] !== 8'h00) begin bad++; $display("FAIL wrap_seqbyte got=%h exp=00", got_q[1]); end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
                if (got_t.size() > 0) void'(got_t.pop_front());
                total++; if (g !== e) begin bad++; $display("FAIL wrap_byte frame=%0d got=%h exp=%h", f, g, e); end
            end
            got_q.delete(); got_t.delete();
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [7:0] e, g;
        start_frame();
        repeat (4) begin @(posedge mclkin); #1; end
        rst = 1'b1;
        @(posedge mclkin); #1;
        rst = 1'b0;
        @(negedge mclkin);
        total++; if (tx0.tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle valid=%b busy=%b exp 0/0", tx0.tx_valid, busy); end
        total++; if (seq_num !== 8'h00) begin bad++; $display("FAIL rstmid_seq got=%h exp=00", seq_num); end
        total++; if (tx0.tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h exp=00", tx0.tx_data); end
        exp_q.delete(); got_q.delete(); got_t.delete();
        m_seq = 8'h00; m_inbuf = '0;
        start_frame();
        wait_bytes(L, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL rstmid_timeout got=%0d exp=%0d", got_q.size(), L); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            if (got_t.size() > 0) void'(got_t.pop_front());
            total++; if (g !== e) begin bad++; $display("FAIL rstmid_byte got=%h exp=%h", g, e); end
        end
        got_q.delete(); got_t.delete();
    endtask

    task automatic test_config();
        logic [7:0] e1[$];
        logic [7:0] e, g;
        int k;
        e1 = '{8'hFF, 8'h00, 8'h12, 8'h34, 8'h56};
`ifdef FRAME_PACKAGER_CSUM_EN
        e1.push_back(8'h64);
`endif
        @(posedge mclkin); #1;
        data1 = 24'h123456; we1 = 1'b1;
        @(posedge mclkin); #1;
        we1 = 1'b0; sync1 = 1'b1;
        @(posedge mclkin); #1;
        sync1 = 1'b0;
        k = 0;
        while (got1_q.size() < e1.size() && k < BUDGET) begin @(posedge mclkin); #1; k++; end
        total++; if (k >= BUDGET) begin bad++; $display("FAIL cfg_timeout got=%0d exp=%0d", got1_q.size(), e1.size()); end
        while (e1.size() > 0) begin
            e = e1.pop_front();
            g = (got1_q.size() > 0) ? got1_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL cfg_byte got=%h exp=%h", g, e); end
        end
        @(negedge mclkin);
        total++; if (seq1 !== 8'h01 || tx1.tx_valid !== 1'b0) begin bad++; $display("FAIL cfg_end seq=%h valid=%b exp 01/0", seq1, tx1.tx_valid); end
    endtask

    initial begin
        rst = 1'b1;
        data_adc = '0; write_enable = 1'b0; sync_pulse = 1'b0;
        data1 = '0; we1 = 1'b0; sync1 = 1'b0;
        tx0.tx_ready = 1'b1; tx1.tx_ready = 1'b1;
        m_seq = 8'h00; m_inbuf = '0; s_cyc = 0;
        repeat (3) @(posedge mclkin);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
